// File: rtl/lane_traffic_collision.sv
// lane_traffic_collision: road lane traffic and frog collision detection.
// One car per lane moves on a score-scaled step tick and wraps at the edge.
// A one-cycle hit pulse is raised, then collisions are held off for a cooldown.
// Ports:
//   i_Clk, i_Rst         clock, async active-high reset
//   i_Game_Active        run traffic and evaluate collisions
//   i_Level_Up           reload cars to their start positions
//   i_Score              current score, sets the step period
//   i_Frog_X, i_Frog_Y   frog top-left position
//   o_Has_Collided       one-cycle collision pulse
//   o_Car_X              packed car left X, lane k at [10k+9:10k]
//   o_Tick               one-cycle pulse per step tick
module lane_traffic_collision #(
    parameter int N_LANES       = 4,
    parameter int TILE_SIZE     = 32,
    parameter int H_VISIBLE_AREA = 640,
    parameter int LANE_Y0       = 128,
    parameter int CAR_LEN       = 64,
    parameter int STEP_PX       = 2,
    parameter int BASE_PERIOD   = 1250000,
    parameter int PERIOD_DEC    = 100000,
    parameter int MIN_PERIOD    = 250000,
    parameter int COOLDOWN      = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Game_Active,
    input  logic                    i_Level_Up,
    input  logic [5:0]              i_Score,
    input  logic [9:0]              i_Frog_X,
    input  logic [9:0]              i_Frog_Y,
    output logic                    o_Has_Collided,
    output logic [10*N_LANES-1:0]   o_Car_X,
    output logic                    o_Tick
);

    localparam int CW = $clog2(COOLDOWN + 1);

    localparam logic [10:0] H_W    = 11'(H_VISIBLE_AREA);
    localparam logic [10:0] STEP_W = 11'(STEP_PX);
    localparam logic [10:0] CAR_W  = 11'(CAR_LEN);
    localparam logic [10:0] TILE_W = 11'(TILE_SIZE);

    localparam logic [31:0] BASE_W = 32'(BASE_PERIOD);
    localparam logic [31:0] DEC_W  = 32'(PERIOD_DEC);
    localparam logic [31:0] MIN_W  = 32'(MIN_PERIOD);

    function automatic logic [N_LANES-1:0][9:0] init_x();
        logic [N_LANES-1:0][9:0] v;
        for (int k = 0; k < N_LANES; k++) begin
            v[k] = 10'((k * H_VISIBLE_AREA) / N_LANES);
        end
        return v;
    endfunction

    localparam logic [N_LANES-1:0][9:0] INIT_X = init_x();

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT,
        COOL
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cool_q, cool_d;
    logic [31:0]                cnt_q, cnt_d;
    logic                       tick_q;
    logic [N_LANES-1:0][9:0]    car_q, car_d;

    logic [31:0]                score_w;
    logic [31:0]                dec_w;
    logic [31:0]                period_w;
    logic                       tick_w;
    logic                       hit_w;
    logic [N_LANES-1:0][10:0]   sum_w;
    logic [N_LANES-1:0][9:0]    step_w;

    // Period saturates at the floor instead of underflowing.
    always_comb begin
        score_w  = (i_Score == 6'd0) ? 32'd1 : {26'd0, i_Score};
        dec_w    = (score_w - 32'd1) * DEC_W;
        period_w = MIN_W;
        if (BASE_W > dec_w && (BASE_W - dec_w) > MIN_W) begin
            period_w = BASE_W - dec_w;
        end
    end

    // Compared with >= so a shorter period takes effect at once.
    assign tick_w = i_Game_Active && (cnt_q >= period_w - 32'd1);

    always_comb begin
        sum_w  = '0;
        step_w = car_q;
        for (int k = 0; k < N_LANES; k++) begin
            if (k % 2 == 0) begin
                sum_w[k] = {1'b0, car_q[k]} + STEP_W;
                if (sum_w[k] >= H_W) begin
                    sum_w[k] = sum_w[k] - H_W;
                end
            end else if ({1'b0, car_q[k]} < STEP_W) begin
                sum_w[k] = {1'b0, car_q[k]} + H_W - STEP_W;
            end else begin
                sum_w[k] = {1'b0, car_q[k]} - STEP_W;
            end
            step_w[k] = sum_w[k][9:0];
        end
    end

    // Car extent past the right edge is deliberately not wrapped here.
    always_comb begin
        hit_w = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            if ({1'b0, i_Frog_Y} == 11'(LANE_Y0 + k * TILE_SIZE) &&
                {1'b0, i_Frog_X} < {1'b0, car_q[k]} + CAR_W &&
                {1'b0, car_q[k]} < {1'b0, i_Frog_X} + TILE_W) begin
                hit_w = 1'b1;
            end
        end
    end

    // Level-up wins over a coincident tick.
    always_comb begin
        cnt_d = cnt_q;
        car_d = car_q;
        if (i_Level_Up) begin
            cnt_d = '0;
            car_d = INIT_X;
        end else if (tick_w) begin
            cnt_d = '0;
            car_d = step_w;
        end else if (i_Game_Active) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            car_q  <= INIT_X;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_w;
            car_q  <= car_d;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cool_d         = cool_q;
        o_Has_Collided = 1'b0;
        if (!i_Game_Active) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (hit_w) begin
                        state_d = HIT;
                    end
                end
                HIT: begin
                    o_Has_Collided = 1'b1;
                    state_d        = COOL;
                    cool_d         = CW'(COOLDOWN);
                end
                COOL: begin
                    cool_d = cool_q - CW'(1);
                    if (cool_q <= CW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_Car_X = car_q;
    assign o_Tick  = tick_q;

endmodule

// File: tb/tb_lane_traffic_collision.sv
// tb_lane_traffic_collision: scoreboard bench for lane_traffic_collision.
// Stimulus queues expected ticks/pulses; a negedge monitor pops and compares.
module tb_lane_traffic_collision;

    logic        clk = 1'b0;
    logic        rst;
    logic        act;
    logic        lvl;
    logic [5:0]  score;
    logic [9:0]  fx;
    logic [9:0]  fy;
    logic        hit;
    logic [39:0] cars;
    logic        tick;

    lane_traffic_collision #(
        .BASE_PERIOD(10),
        .PERIOD_DEC(2),
        .MIN_PERIOD(4)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Game_Active(act),
        .i_Level_Up(lvl),
        .i_Score(score),
        .i_Frog_X(fx),
        .i_Frog_Y(fy),
        .o_Has_Collided(hit),
        .o_Car_X(cars),
        .o_Tick(tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total = 0;
    int tick_seen = 0;
    int hit_seen = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [39:0] cars;
    } tick_exp_t;

    tick_exp_t tq[$];
    int        cq[$];
    logic [9:0] mx [4];

    localparam logic [39:0] INIT = {10'd480, 10'd320, 10'd160, 10'd0};

    task automatic chk(input string nm, input logic [39:0] got,
                       input logic [39:0] want);
        total++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    function automatic logic [39:0] pack();
        return {mx[3], mx[2], mx[1], mx[0]};
    endfunction

    task automatic model_reset();
        mx[0] = 10'd0;
        mx[1] = 10'd160;
        mx[2] = 10'd320;
        mx[3] = 10'd480;
    endtask

    task automatic model_step();
        int x;
        for (int k = 0; k < 4; k++) begin
            x = int'(mx[k]);
            if (k % 2 == 0) begin
                x = x + 2;
                if (x >= 640) x = x - 640;
            end else begin
                x = x - 2;
                if (x < 0) x = x + 640;
            end
            mx[k] = 10'(x);
        end
    endtask

    // Call right after a tick edge (or with the counter at 0).
    task automatic expect_ticks(input int p, input int n);
        tick_exp_t e;
        for (int i = 0; i < n; i++) begin
            model_step();
            e.cyc  = 32'(cyc + p);
            e.cars = pack();
            tq.push_back(e);
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        tick_exp_t e;
        int c;
        if (!rst) begin
            if (tick) begin
                tick_seen++;
                if (tq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_tick at cycle %0d", cyc);
                end else begin
                    e = tq.pop_front();
                    chk("tick_cycle", 40'(cyc), 40'(e.cyc));
                    chk("tick_cars", cars, e.cars);
                end
            end
            if (hit) begin
                hit_seen++;
                if (cq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_hit at cycle %0d", cyc);
                end else begin
                    c = cq.pop_front();
                    chk("hit_cycle", 40'(cyc), 40'(c));
                end
            end
        end
    end

    initial begin
        int m;
        int n;
        int c0;
        int t0;
        tick_exp_t e;
        rst   = 1'b1;
        act   = 1'b0;
        lvl   = 1'b0;
        score = 6'd1;
        fx    = 10'd0;
        fy    = 10'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cars", cars, INIT);
        chk("reset_tick", 40'(tick), 40'd0);
        chk("reset_hit", 40'(hit), 40'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Base period, then faster, then floor held.
        act = 1'b1;
        expect_ticks(10, 2);
        score = 6'd3;
        expect_ticks(6, 2);
        score = 6'd63;
        expect_ticks(4, 318);

        // Level-up coincident with the next tick.
        m = cyc;
        repeat (3) @(posedge clk);
        #1;
        lvl = 1'b1;
        model_reset();
        e.cyc  = 32'(m + 4);
        e.cars = pack();
        tq.push_back(e);
        @(posedge clk);
        #1;
        lvl   = 1'b0;
        score = 6'd1;

        // Edge touch and off-lane Y give no hit while lane0 sits at 0.
        fork
            expect_ticks(10, 1);
            begin
                c0 = hit_seen;
                fx = 10'd64;
                fy = 10'd128;
                repeat (4) @(posedge clk);
                #1;
                fx = 10'd16;
                fy = 10'd144;
                repeat (4) @(posedge clk);
                #1;
                fy = 10'd0;
                chk("edge_no_hit", 40'(hit_seen), 40'(c0));
            end
        join

        // Held overlap: pulse, cooldown, second pulse.
        n = cyc;
        fork
            expect_ticks(10, 2);
            begin
                fx = 10'd16;
                fy = 10'd128;
                cq.push_back(n + 1);
                cq.push_back(n + 7);
                repeat (8) @(posedge clk);
                #1;
                fy = 10'd0;
                repeat (8) @(posedge clk);
                #1;
            end
        join

        // Drop game-active in HIT: pulse suppressed, state frozen.
        fx = 10'd16;
        fy = 10'd128;
        @(posedge clk);
        #1;
        act = 1'b0;
        #1;
        chk("inactive_hit_low", 40'(hit), 40'd0);
        c0 = hit_seen;
        t0 = tick_seen;
        repeat (20) @(posedge clk);
        #1;
        chk("frozen_cars", cars, pack());
        chk("frozen_no_hit", 40'(hit_seen), 40'(c0));
        chk("frozen_no_tick", 40'(tick_seen), 40'(t0));

        // Async reset drops an in-flight pulse.
        fy  = 10'd0;
        act = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fy = 10'd128;
        @(posedge clk);
        #1;
        chk("pre_reset_hit", 40'(hit), 40'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_hit", 40'(hit), 40'd0);
        chk("async_rst_tick", 40'(tick), 40'd0);
        chk("async_rst_cars", cars, INIT);
        repeat (2) @(posedge clk);
        #1;
        chk("tick_queue_drained", 40'(tq.size()), 40'd0);
        chk("hit_queue_drained", 40'(cq.size()), 40'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
